// File: rtl/mux_nx1_scan_pkg.sv
// Shared constants, mode encoding and channel-increment helper for mux_nx1_scan.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mux_pkg;

    localparam int WIDTH_DEF  = 4;
    localparam int NUM_CH_DEF = 4;
    localparam int DWELL_DEF  = 3;

    // Wide enough to hold any channel index up to the 16-channel maximum.
    localparam int CH_IDX_W   = 4;

    typedef enum logic {
        MODE_MANUAL = 1'b0,
        MODE_AUTO   = 1'b1
    } mode_e;

    // Round-robin increment; wraps on an explicit compare against the last
    // channel so non-power-of-2 channel counts never rely on bit overflow.
    function automatic logic [CH_IDX_W-1:0] next_ch(input logic [CH_IDX_W-1:0] cur,
                                                    input int num_ch);
        if (int'(cur) >= num_ch - 1) begin
            return '0;
        end
        return cur + CH_IDX_W'(1);
    endfunction

endpackage

// File: rtl/mux_nx1_scan_if.sv
// Channel data / select / status bundle between the switch banks and mux_nx1_scan.
// Latency: n/a (wires only).
// Backpressure: none; the mux samples every cycle.
// master = driver of channel data and controls, slave = the mux.
// With MUX_SCAN_SKIP_EN defined the bundle also carries the per-channel Mask.
interface mux_nx1_scan_if
    import mux_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int NUM_CH = NUM_CH_DEF
);
    localparam int SEL_W = $clog2(NUM_CH);

    logic [NUM_CH*WIDTH-1:0] D_IN;
    logic [SEL_W-1:0]        Sel;
    logic                    Auto;
`ifdef MUX_SCAN_SKIP_EN
    logic [NUM_CH-1:0]       Mask;
`endif
    logic [WIDTH-1:0]        F;
    logic [SEL_W-1:0]        CH;
    logic                    Chg;
    logic                    Err;

`ifdef MUX_SCAN_SKIP_EN
    modport master (output D_IN, Sel, Auto, Mask, input F, CH, Chg, Err);
    modport slave  (input D_IN, Sel, Auto, Mask, output F, CH, Chg, Err);
`else
    modport master (output D_IN, Sel, Auto, input F, CH, Chg, Err);
    modport slave  (input D_IN, Sel, Auto, output F, CH, Chg, Err);
`endif

endinterface

// File: rtl/mux_dwell_cnt.sv
// Dwell counter for auto-scan: counts 0..DWELL-1, flags the last cycle of a dwell.
// Latency: tc is combinational from the registered count (same cycle).
// Backpressure: none; enable gates counting, clear forces the count to 0.
// Ports: clk, rst_n (sync, active-low), enable, clear -> tc (terminal-count pulse).
module mux_dwell_cnt #(
    parameter int DWELL = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic clear,
    output logic tc
);
    // DWELL=1 still needs a 1-bit counter (it simply stays at 0).
    localparam int              CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL - 1);

    logic [CNT_W-1:0] cnt;

    assign tc = enable && !clear && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mux_nx1_scan.sv
// NUM_CH x WIDTH to 1 registered mux with manual select or round-robin auto-scan.
// Latency: 1 cycle from D_IN/Sel/Auto to F, CH, Chg, Err (all registered together).
// Backpressure: none; inputs are sampled every rising edge.
// Ports: clk, rst_n (sync, active-low), bus (mux_nx1_scan_if.slave: D_IN, Sel,
// Auto [, Mask] in; F, CH, Chg, Err out). Optional macro MUX_SCAN_SKIP_EN adds
// Mask: auto-scan skips masked-off channels, manual select of one flags Err.
module mux_nx1_scan
    import mux_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int NUM_CH = NUM_CH_DEF,
    parameter int DWELL  = DWELL_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    mux_nx1_scan_if.slave  bus
);
    localparam int SEL_W = $clog2(NUM_CH);

    mode_e            mode;
    logic             tc;
    logic [SEL_W-1:0] ch_q;
    logic [SEL_W-1:0] ch_nxt;
    logic [SEL_W-1:0] ch_inc;
    logic             sel_ok;
    logic             err_nxt;
    logic [WIDTH-1:0] f_q;
    logic [WIDTH-1:0] f_nxt;
    logic             chg_q;
    logic             err_q;

    assign mode = mode_e'(bus.Auto);

    // Counter is held at 0 in manual mode, so entering auto always starts a
    // fresh dwell on the current channel.
    mux_dwell_cnt #(.DWELL(DWELL)) u_dwell (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (mode == MODE_AUTO),
        .clear  (mode == MODE_MANUAL),
        .tc     (tc)
    );

    assign ch_inc = SEL_W'(next_ch(CH_IDX_W'(ch_q), NUM_CH));

`ifdef MUX_SCAN_SKIP_EN
    localparam int SEL_SPAN = 1 << SEL_W;

    logic [SEL_SPAN-1:0] mask_ext;
    logic [SEL_W-1:0]    ch_skip;

    // Zero-extend so an out-of-range Sel indexes a 0 bit instead of running off the end.
    assign mask_ext = SEL_SPAN'(bus.Mask);
    assign sel_ok   = (int'(bus.Sel) < NUM_CH) && mask_ext[bus.Sel];

    // First enabled channel strictly after ch_q, searching upward with wrap;
    // lands back on ch_q when it is the only enabled one.
    always_comb begin
        int  idx;
        logic found;
        idx     = 0;
        found   = 1'b0;
        ch_skip = ch_q;
        for (int i = 1; i <= NUM_CH; i++) begin
            idx = (int'(ch_q) + i) % NUM_CH;
            if (!found && bus.Mask[idx]) begin
                ch_skip = SEL_W'(idx);
                found   = 1'b1;
            end
        end
    end
`else
    assign sel_ok = (int'(bus.Sel) < NUM_CH);
`endif

    always_comb begin
        ch_nxt  = ch_q;
        err_nxt = 1'b0;
        if (mode == MODE_AUTO) begin
`ifdef MUX_SCAN_SKIP_EN
            if (bus.Mask == '0) begin
                err_nxt = 1'b1;
            end else if (tc) begin
                ch_nxt = ch_skip;
            end
`else
            if (tc) begin
                ch_nxt = ch_inc;
            end
`endif
        end else begin
            if (sel_ok) begin
                ch_nxt = bus.Sel;
            end else begin
                err_nxt = 1'b1;
            end
        end
    end

    // F follows the next-state channel so F and CH move on the same edge.
    always_comb begin
        f_nxt = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (int'(ch_nxt) == k) begin
                f_nxt = bus.D_IN[k*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            f_q   <= '0;
            ch_q  <= '0;
            chg_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            f_q   <= f_nxt;
            ch_q  <= ch_nxt;
            chg_q <= (ch_nxt != ch_q);
            err_q <= err_nxt;
        end
    end

    assign bus.F   = f_q;
    assign bus.CH  = ch_q;
    assign bus.Chg = chg_q;
    assign bus.Err = err_q;

endmodule

// File: tb/tb_mux_nx1_scan.sv
// Bench for mux_nx1_scan: three builds (4ch/dwell 3, 3ch/dwell 3, 4ch/dwell 1)
// driven in lockstep, checked by hand vectors and by a cycle-level reference model.
// Ends with one summary line.
module tb_mux_nx1_scan;

    logic        clk;
    logic        rst_n;
    logic [15:0] d;
    int          sel;
    bit          auto_m;

    int total = 0;
    int bad   = 0;

    mux_nx1_scan_if #(.WIDTH(4), .NUM_CH(4)) if4 ();
    mux_nx1_scan_if #(.WIDTH(4), .NUM_CH(3)) if3 ();
    mux_nx1_scan_if #(.WIDTH(4), .NUM_CH(4)) if1 ();

    mux_nx1_scan #(.WIDTH(4), .NUM_CH(4), .DWELL(3)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));
    mux_nx1_scan #(.WIDTH(4), .NUM_CH(3), .DWELL(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(if3.slave));
    mux_nx1_scan #(.WIDTH(4), .NUM_CH(4), .DWELL(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: channel index as a plain integer, plus how many auto
    // cycles have been spent on it; a channel is left once DWELL cycles are used.
    typedef struct {
        int ch;
        int since;
        int f;
        int chg;
        int err;
    } mstate_t;

    mstate_t m4, m3, m1;

    function automatic mstate_t model_step(mstate_t s, int n, int dwell, bit rst,
                                           logic [63:0] dd, int sl, bit au);
        mstate_t r;
        int old;
        r   = s;
        old = s.ch;
        if (!rst) begin
            r = '{0, 0, 0, 0, 0};
            return r;
        end
        if (au) begin
            r.since = r.since + 1;
            if (r.since == dwell) begin
                r.since = 0;
                r.ch    = (r.ch + 1) % n;
            end
            r.err = 0;
        end else begin
            r.since = 0;
            if (sl < n) begin
                r.ch  = sl;
                r.err = 0;
            end else begin
                r.err = 1;
            end
        end
        r.f   = int'((dd >> (4 * r.ch)) & 64'hF);
        r.chg = (r.ch != old) ? 1 : 0;
        return r;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive();
        if4.D_IN = d;
        if3.D_IN = d[11:0];
        if1.D_IN = d;
        if4.Sel  = 2'(sel);
        if3.Sel  = 2'(sel);
        if1.Sel  = 2'(sel);
        if4.Auto = auto_m;
        if3.Auto = auto_m;
        if1.Auto = auto_m;
`ifdef MUX_SCAN_SKIP_EN
        if4.Mask = '1;
        if3.Mask = '1;
        if1.Mask = '1;
`endif
    endtask

    // One edge with the currently driven inputs; sample 1 time unit later.
    task automatic cycle();
        @(posedge clk);
        #1;
        m4 = model_step(m4, 4, 3, rst_n, 64'(d), sel, auto_m);
        m3 = model_step(m3, 3, 3, rst_n, 64'(d[11:0]), sel, auto_m);
        m1 = model_step(m1, 4, 1, rst_n, 64'(d), sel, auto_m);
        chk("m4.F",   int'(if4.F),   m4.f);
        chk("m4.CH",  int'(if4.CH),  m4.ch);
        chk("m4.Chg", int'(if4.Chg), m4.chg);
        chk("m4.Err", int'(if4.Err), m4.err);
        chk("m3.F",   int'(if3.F),   m3.f);
        chk("m3.CH",  int'(if3.CH),  m3.ch);
        chk("m3.Chg", int'(if3.Chg), m3.chg);
        chk("m3.Err", int'(if3.Err), m3.err);
        chk("m1.F",   int'(if1.F),   m1.f);
        chk("m1.CH",  int'(if1.CH),  m1.ch);
        chk("m1.Chg", int'(if1.Chg), m1.chg);
        chk("m1.Err", int'(if1.Err), m1.err);
    endtask

    typedef struct {
        bit          rst;
        logic [15:0] dv;
        int          sl;
        bit          au;
        int          f;
        int          ch;
        int          chg;
        int          err;
    } vec_t;

    vec_t tbl[$];

    initial begin
        // reset, then release with Sel=2
        tbl.push_back('{0, 16'hF96A, 2, 0, 0,   0, 0, 0});
        tbl.push_back('{0, 16'hF96A, 2, 0, 0,   0, 0, 0});
        tbl.push_back('{1, 16'hF96A, 2, 0, 9,   2, 1, 0});
        tbl.push_back('{1, 16'hF96A, 2, 0, 9,   2, 0, 0});
        // manual 0 -> 1 -> 1
        tbl.push_back('{1, 16'h0F0F, 0, 0, 'hF, 0, 1, 0});
        tbl.push_back('{1, 16'h0F0F, 1, 0, 0,   1, 1, 0});
        tbl.push_back('{1, 16'h0F0F, 1, 0, 0,   1, 0, 0});
        // park on ch0, then auto-scan (Sel=3 must be ignored)
        tbl.push_back('{1, 16'h4321, 0, 0, 1,   0, 1, 0});
        tbl.push_back('{1, 16'h4321, 3, 1, 1,   0, 0, 0});
        tbl.push_back('{1, 16'h4321, 3, 1, 1,   0, 0, 0});
        tbl.push_back('{1, 16'h4321, 3, 1, 2,   1, 1, 0});
        tbl.push_back('{1, 16'h4321, 3, 1, 2,   1, 0, 0});
        tbl.push_back('{1, 16'h4321, 3, 1, 2,   1, 0, 0});
        tbl.push_back('{1, 16'h4321, 3, 1, 3,   2, 1, 0});
        tbl.push_back('{1, 16'h4321, 3, 1, 3,   2, 0, 0});
        tbl.push_back('{1, 16'h4321, 3, 1, 3,   2, 0, 0});
        tbl.push_back('{1, 16'h4321, 3, 1, 4,   3, 1, 0});
        tbl.push_back('{1, 16'h4321, 3, 1, 4,   3, 0, 0});
        tbl.push_back('{1, 16'h4321, 3, 1, 4,   3, 0, 0});
        tbl.push_back('{1, 16'h4321, 3, 1, 1,   0, 1, 0});
        // continue to ch2 with one dwell cycle spent, then reset mid-scan
        tbl.push_back('{1, 16'h4321, 3, 1, 1,   0, 0, 0});
        tbl.push_back('{1, 16'h4321, 3, 1, 1,   0, 0, 0});
        tbl.push_back('{1, 16'h4321, 3, 1, 2,   1, 1, 0});
        tbl.push_back('{1, 16'h4321, 3, 1, 2,   1, 0, 0});
        tbl.push_back('{1, 16'h4321, 3, 1, 2,   1, 0, 0});
        tbl.push_back('{1, 16'h4321, 3, 1, 3,   2, 1, 0});
        tbl.push_back('{1, 16'h4321, 3, 1, 3,   2, 0, 0});
        tbl.push_back('{0, 16'h4321, 3, 1, 0,   0, 0, 0});
        tbl.push_back('{1, 16'h4321, 3, 1, 1,   0, 0, 0});
        tbl.push_back('{1, 16'h4321, 3, 1, 1,   0, 0, 0});
        tbl.push_back('{1, 16'h4321, 3, 1, 2,   1, 1, 0});

        m4 = '{0, 0, 0, 0, 0};
        m3 = '{0, 0, 0, 0, 0};
        m1 = '{0, 0, 0, 0, 0};
        rst_n  = 1'b0;
        d      = '0;
        sel    = 0;
        auto_m = 1'b0;
        drive();

        foreach (tbl[i]) begin
            rst_n  = tbl[i].rst;
            d      = tbl[i].dv;
            sel    = tbl[i].sl;
            auto_m = tbl[i].au;
            drive();
            cycle();
            chk($sformatf("row%0d.F", i),   int'(if4.F),   tbl[i].f);
            chk($sformatf("row%0d.CH", i),  int'(if4.CH),  tbl[i].ch);
            chk($sformatf("row%0d.Chg", i), int'(if4.Chg), tbl[i].chg);
            chk($sformatf("row%0d.Err", i), int'(if4.Err), tbl[i].err);
        end

        // 3-channel build: out-of-range select holds CH and raises Err
        rst_n  = 1'b1;
        auto_m = 1'b0;
        d      = 16'h0321;
        sel    = 2;
        drive();
        cycle();
        chk("n3.sel2.CH",  int'(if3.CH),  2);
        chk("n3.sel2.F",   int'(if3.F),   3);
        sel = 3;
        drive();
        cycle();
        chk("n3.sel3.CH",  int'(if3.CH),  2);
        chk("n3.sel3.F",   int'(if3.F),   3);
        chk("n3.sel3.Err", int'(if3.Err), 1);
        chk("n3.sel3.Chg", int'(if3.Chg), 0);
        sel = 1;
        drive();
        cycle();
        chk("n3.sel1.CH",  int'(if3.CH),  1);
        chk("n3.sel1.F",   int'(if3.F),   2);
        chk("n3.sel1.Err", int'(if3.Err), 0);
        chk("n3.sel1.Chg", int'(if3.Chg), 1);

        // randomized traffic: long mode runs, rare resets, frequent data changes
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 7) == 0) auto_m = ~auto_m;
            rst_n = ($urandom_range(0, 39) != 0);
            sel   = int'($urandom_range(0, 3));
            if ($urandom_range(0, 2) == 0) d = 16'($urandom);
            drive();
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
